multiword_adder_seq: RTL and testbench

Multi-cycle, multi-precision add/subtract sequencer. It reuses a single `ripple_carry_adder #(.WIDTH(WIDTH))` instance over CHUNKS clock cycles to add or subtract operands of WIDTH*CHUNKS bits, least-significant chunk first. The carry is registered between chunks. The block sits in the ALU path wherever a wide result is needed and area matters more than latency. It has a valid/ready handshake on both input and output.

---
 rtl/multiword_adder_seq.sv | 152 +++++++++++++++
 tb/tb_multiword_adder_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_adder_seq.sv
// Multi-precision add/subtract that reuses one WIDTH-bit ripple adder over CHUNKS cycles, least-significant chunk first.
// Optional feature macro: MWADD_OVF_EN adds the registered signed-overflow output Ovf.

module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // Bit-level carry chain, LSB to MSB
  always_comb begin : p_chain
    logic v_c;
    v_c   = i_cin;
    o_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ v_c;
      v_c      = (i_a[i] & i_b[i]) | (v_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = v_c;
  end

endmodule

module multiword_adder_seq #(
  parameter int WIDTH  = 8,
  parameter int CHUNKS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*CHUNKS-1:0] A,
  input  logic [WIDTH*CHUNKS-1:0] B,
  input  logic                    Sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*CHUNKS-1:0] Sum,
  output logic                    Cout
`ifdef MWADD_OVF_EN
  ,
  output logic                    Ovf
`endif
);

  localparam int TOT  = WIDTH * CHUNKS;
  localparam int IDXW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [TOT-1:0]   r_a;
  logic [TOT-1:0]   r_b;
  logic [TOT-1:0]   r_sum;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH-1:0] w_a_chunk;
  logic [WIDTH-1:0] w_b_chunk;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_a_chunk = r_a[r_idx*WIDTH +: WIDTH];
  assign w_b_chunk = r_b[r_idx*WIDTH +: WIDTH];

  ripple_carry_adder #(.WIDTH(WIDTH)) u_rca (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Handshake flags decode from the state register only
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign Sum       = r_sum;
  assign Cout      = r_cout;
`ifdef MWADD_OVF_EN
  assign Ovf       = r_ovf;
`endif

  // Sequencer: accept, one chunk per RUN cycle, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= Sub ? ~B : B;
            r_carry <= Sub;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sum[r_idx*WIDTH +: WIDTH] <= w_sum;
          r_carry                     <= w_cout;
          if (r_idx == LAST_IDX) begin
            // Index returns to 0 so the chunk mux never points past the operand
            r_idx   <= '0;
            r_cout  <= w_cout;
`ifdef MWADD_OVF_EN
            r_ovf   <= (r_a[TOT-1] == r_b[TOT-1]) && (w_sum[WIDTH-1] != r_a[TOT-1]);
`else
            r_ovf   <= 1'b0;
`endif
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + IDXW'(1);
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Self-checking bench for multiword_adder_seq (WIDTH=8, CHUNKS=4) against an arithmetic reference model.

module tb_multiword_adder_seq;

  localparam int W   = 8;
  localparam int C   = 4;
  localparam int TOT = W * C;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [TOT-1:0] A;
  logic [TOT-1:0] B;
  logic           Sub;
  logic           out_valid;
  logic           out_ready;
  logic [TOT-1:0] Sum;
  logic           Cout;
`ifdef MWADD_OVF_EN
  logic           Ovf;
`endif

  int checks;
  int errors;

  multiword_adder_seq #(.WIDTH(W), .CHUNKS(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
`ifdef MWADD_OVF_EN
    ,
    .Ovf       (Ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the full-width operands
  function automatic logic [TOT-1:0] ref_sum(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic s);
    return s ? (a - b) : (a + b);
  endfunction

  function automatic logic ref_cout(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic s);
    logic [TOT:0] wide;
    wide = {1'b0, a} + {1'b0, b};
    return s ? (a >= b) : wide[TOT];
  endfunction

  function automatic logic ref_ovf(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic s);
    longint r;
    r = s ? (longint'($signed(a)) - longint'($signed(b))) : (longint'($signed(a)) + longint'($signed(b)));
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Accept one operation, measure latency, check result, then hand it off
  task automatic run_op(input string name, input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic s);
    int lat;
    logic [TOT-1:0] es;
    logic ec;
    es = ref_sum(a, b, s);
    ec = ref_cout(a, b, s);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    A = a; B = b; Sub = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; Sub = $urandom_range(0, 1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== C) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, C);
    end
    checks++;
    if (Sum !== es) begin
      errors++;
      $display("FAIL %s Sum: got %h want %h", name, Sum, es);
    end
    checks++;
    if (Cout !== ec) begin
      errors++;
      $display("FAIL %s Cout: got %b want %b", name, Cout, ec);
    end
`ifdef MWADD_OVF_EN
    checks++;
    if (Ovf !== ref_ovf(a, b, s)) begin
      errors++;
      $display("FAIL %s Ovf: got %b want %b", name, Ovf, ref_ovf(a, b, s));
    end
`endif
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handoff: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Sum !== 32'h0 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL reset: got in_ready=%b out_valid=%b Sum=%h Cout=%b want 1/0/0/0", in_ready, out_valid, Sum, Cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op("add_ff_1",     32'h000000FF, 32'h00000001, 1'b0);
    run_op("add_wrap",     32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_op("sub_borrow",   32'h00000005, 32'h00000007, 1'b1);
    run_op("sub_noborrow", 32'h00000007, 32'h00000005, 1'b1);
    run_op("add_sovf",     32'h7FFFFFFF, 32'h00000001, 1'b0);
    run_op("sub_sovf",     32'h80000000, 32'h00000001, 1'b1);
    run_op("sub_minneg",   32'h00000000, 32'h80000000, 1'b1);
    run_op("sub_zero",     32'h80000000, 32'h00000000, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op("random", $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_backpressure();
    logic [TOT-1:0] es;
    es = ref_sum(32'hDEADBEEF, 32'h01020304, 1'b0);
    @(negedge clk);
    A = 32'hDEADBEEF; B = 32'h01020304; Sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      A = $urandom; B = $urandom; Sub = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Sum !== es || Cout !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold: got out_valid=%b in_ready=%b Sum=%h Cout=%b want 1/0/%h/0",
                 out_valid, in_ready, Sum, Cout, es);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    repeat (C + 2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure queued_req: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; Sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Sum !== 32'h0 || Cout !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reset: got Sum=%h Cout=%b out_valid=%b in_ready=%b want 0/0/0/1",
               Sum, Cout, out_valid, in_ready);
    end
`ifdef MWADD_OVF_EN
    checks++;
    if (Ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset Ovf: got %b want 0", Ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 32'h12345678, 32'h11111111, 1'b0);
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    int outs;
    logic [TOT-1:0] es;
    es = ref_sum(32'h0F0F0F0F, 32'h10101010, 1'b0);
    outs = 0;
    @(negedge clk);
    A = 32'h0F0F0F0F; B = 32'h10101010; Sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 3 * (C + 2) + 1; cyc++) begin
      if (in_ready === 1'b1) accepts.push_back(cyc);
      if (out_valid === 1'b1) begin
        outs++;
        checks++;
        if (Sum !== es) begin
          errors++;
          $display("FAIL b2b Sum: got %h want %h", Sum, es);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (accepts.size() !== 4 || outs !== 3) begin
      errors++;
      $display("FAIL b2b counts: got accepts=%0d outs=%0d want 4/3", accepts.size(), outs);
    end
    for (int i = 1; i < accepts.size(); i++) begin
      checks++;
      if (accepts[i] - accepts[i-1] !== C + 2) begin
        errors++;
        $display("FAIL b2b interval: got %0d want %0d", accepts[i] - accepts[i-1], C + 2);
      end
    end
    repeat (C + 2) @(posedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
